// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester ports (A = fetch,
// B = load/store), the shared slave port and the grant indicator.
// The master modport is the arbiter's view; the slave modport is the
// view of the surrounding requesters and memory target.
interface mem_port_arbiter_if #(
   parameter int EXC_W = 4
);
   logic [31:0]      a_addr_In;
   logic [31:0]      a_data_In;
   logic [1:0]       a_dataWidth_In;
   logic             a_isRead_In;
   logic             a_valid_In;
   logic             a_ok_Out;
   logic [31:0]      a_data_Out;
   logic [EXC_W-1:0] a_exception_Out;

   logic [31:0]      b_addr_In;
   logic [31:0]      b_data_In;
   logic [1:0]       b_dataWidth_In;
   logic             b_isRead_In;
   logic             b_valid_In;
   logic             b_ok_Out;
   logic [31:0]      b_data_Out;
   logic [EXC_W-1:0] b_exception_Out;

   logic [31:0]      s_addr_Out;
   logic [31:0]      s_data_Out;
   logic [1:0]       s_dataWidth_Out;
   logic             s_isRead_Out;
   logic             s_select_Out;
   logic             s_finish_In;
   logic [31:0]      s_data_In;
   logic [EXC_W-1:0] s_exception_In;

   logic [1:0]       grant_Out;

   modport master (
      input  a_addr_In, a_data_In, a_dataWidth_In, a_isRead_In, a_valid_In,
      output a_ok_Out, a_data_Out, a_exception_Out,
      input  b_addr_In, b_data_In, b_dataWidth_In, b_isRead_In, b_valid_In,
      output b_ok_Out, b_data_Out, b_exception_Out,
      output s_addr_Out, s_data_Out, s_dataWidth_Out, s_isRead_Out, s_select_Out,
      input  s_finish_In, s_data_In, s_exception_In,
      output grant_Out
   );

   modport slave (
      output a_addr_In, a_data_In, a_dataWidth_In, a_isRead_In, a_valid_In,
      input  a_ok_Out, a_data_Out, a_exception_Out,
      output b_addr_In, b_data_In, b_dataWidth_In, b_isRead_In, b_valid_In,
      input  b_ok_Out, b_data_Out, b_exception_Out,
      input  s_addr_Out, s_data_Out, s_dataWidth_Out, s_isRead_Out, s_select_Out,
      output s_finish_In, s_data_In, s_exception_In,
      input  grant_Out
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master, one-slave memory port arbiter with round-robin grant.
// A transaction walks IDLE -> BUSY -> RESP -> RELEASE; the request fields
// are latched on grant and the slave response is routed back to the owner
// as a one-cycle ok pulse.
// Optional feature macro: ARB_TIMEOUT_EN adds a bus-timeout watchdog that
// ends a BUSY phase after TIMEOUT_CYCLES cycles with EXC_BUS_TIMEOUT.
module mem_port_arbiter #(
   parameter int EXC_W           = 4,
   parameter int EXC_OK          = 0,
   parameter int EXC_BUS_TIMEOUT = 9,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESP    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [1:0]       owner;
   logic             last_b;
   logic             pick_a;
   logic             pick_b;
   logic             finish;
   logic             expire;

   logic [31:0]      s_addr;
   logic [31:0]      s_data;
   logic [1:0]       s_width;
   logic             s_is_read;
   logic [31:0]      a_rdata;
   logic [31:0]      b_rdata;
   logic [EXC_W-1:0] a_exc;
   logic [EXC_W-1:0] b_exc;

   // Round-robin pick: a lone requester wins, on a tie the master that
   // was not served last wins.
   always_comb begin
      pick_a = bus.a_valid_In && (!bus.b_valid_In || last_b);
      pick_b = bus.b_valid_In && !pick_a;
      finish = (state == BUSY) && bus.s_finish_In;
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] wd_cnt;

   // Watchdog counter: zero outside BUSY, counts each BUSY cycle.
   always_ff @(posedge clk) begin
      if (rst || state != BUSY)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end

   // Expiry fires on the last budgeted BUSY cycle; a real finish wins.
   always_comb begin
      expire = (state == BUSY) && !bus.s_finish_In &&
               (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   end
`else
   // Without the watchdog, BUSY waits for the slave indefinitely.
   always_comb begin
      expire = 1'b0;
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic for the four-phase transaction.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pick_a || pick_b) state_next = BUSY;
         BUSY:    if (finish || expire) state_next = RESP;
         RESP:    state_next = RELEASE;
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request latching on grant and response capture for the owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_addr    <= '0;
         s_data    <= '0;
         s_width   <= '0;
         s_is_read <= 1'b0;
         owner     <= 2'b00;
         last_b    <= 1'b1;
         a_rdata   <= '0;
         b_rdata   <= '0;
         a_exc     <= EXC_W'(EXC_OK);
         b_exc     <= EXC_W'(EXC_OK);
      end else begin
         case (state)
            IDLE: begin
               if (pick_a) begin
                  s_addr    <= bus.a_addr_In;
                  s_data    <= bus.a_data_In;
                  s_width   <= bus.a_dataWidth_In;
                  s_is_read <= bus.a_isRead_In;
                  owner     <= 2'b01;
                  last_b    <= 1'b0;
               end else if (pick_b) begin
                  s_addr    <= bus.b_addr_In;
                  s_data    <= bus.b_data_In;
                  s_width   <= bus.b_dataWidth_In;
                  s_is_read <= bus.b_isRead_In;
                  owner     <= 2'b10;
                  last_b    <= 1'b1;
               end
            end
            BUSY: begin
               if (finish) begin
                  if (owner[0]) begin
                     a_rdata <= bus.s_data_In;
                     a_exc   <= bus.s_exception_In;
                  end
                  if (owner[1]) begin
                     b_rdata <= bus.s_data_In;
                     b_exc   <= bus.s_exception_In;
                  end
               end else if (expire) begin
                  if (owner[0]) begin
                     a_rdata <= '0;
                     a_exc   <= EXC_W'(EXC_BUS_TIMEOUT);
                  end
                  if (owner[1]) begin
                     b_rdata <= '0;
                     b_exc   <= EXC_W'(EXC_BUS_TIMEOUT);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decoded from the current phase and owner.
   always_comb begin
      bus.s_select_Out    = (state == BUSY);
      bus.grant_Out       = (state == BUSY || state == RESP) ? owner : 2'b00;
      bus.a_ok_Out        = (state == RESP) && owner[0];
      bus.b_ok_Out        = (state == RESP) && owner[1];
      bus.a_data_Out      = a_rdata;
      bus.b_data_Out      = b_rdata;
      bus.a_exception_Out = a_exc;
      bus.b_exception_Out = b_exc;
      bus.s_addr_Out      = s_addr;
      bus.s_data_Out      = s_data;
      bus.s_dataWidth_Out = s_width;
      bus.s_isRead_Out    = s_is_read;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: single read, round-robin
// order, write field latching, slave exceptions, watchdog (when
// ARB_TIMEOUT_EN is defined), stray finish strobes and mid-BUSY reset.
module tb_mem_port_arbiter;

   localparam logic [3:0] EXC_OK_V      = 4'd0;
   localparam logic [3:0] EXC_TIMEOUT_V = 4'd9;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mem_port_arbiter_if #(.EXC_W(4)) bus ();

   mem_port_arbiter #(
      .EXC_W(4),
      .EXC_OK(0),
      .EXC_BUS_TIMEOUT(9),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      bus.a_valid_In  = 1'b0;
      bus.b_valid_In  = 1'b0;
      bus.s_finish_In = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      bus.a_valid_In = 1'b1;
      bus.a_addr_In  = 32'hFFFF_0000;
      do_reset();
      checks++; if (bus.s_select_Out !== 1'b0) begin errors++; $display("[TB] FAIL reset_select: got %b want 0", bus.s_select_Out); end
      checks++; if (bus.grant_Out !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b want 00", bus.grant_Out); end
      checks++; if ({bus.a_ok_Out, bus.b_ok_Out} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ok: got %b want 00", {bus.a_ok_Out, bus.b_ok_Out}); end
      checks++; if (bus.s_addr_Out !== 32'h0) begin errors++; $display("[TB] FAIL reset_saddr: got %h want 0", bus.s_addr_Out); end
      checks++; if (bus.a_data_Out !== 32'h0 || bus.a_exception_Out !== EXC_OK_V) begin errors++; $display("[TB] FAIL reset_adata: got %h/%h want 0/0", bus.a_data_Out, bus.a_exception_Out); end
      tick();
      checks++; if (bus.s_select_Out !== 1'b0 || bus.grant_Out !== 2'b00) begin errors++; $display("[TB] FAIL idle_stays: got sel %b grant %b want 0/00", bus.s_select_Out, bus.grant_Out); end
   endtask

   task automatic test_single_read;
      bus.a_addr_In      = 32'h0000_0100;
      bus.a_data_In      = 32'h0;
      bus.a_dataWidth_In = 2'b10;
      bus.a_isRead_In    = 1'b1;
      bus.a_valid_In     = 1'b1;
      tick();
      checks++; if (bus.s_select_Out !== 1'b1 || bus.grant_Out !== 2'b01) begin errors++; $display("[TB] FAIL read_grant: got sel %b grant %b want 1/01", bus.s_select_Out, bus.grant_Out); end
      checks++; if (bus.s_addr_Out !== 32'h100 || bus.s_isRead_Out !== 1'b1) begin errors++; $display("[TB] FAIL read_fields: got %h/%b want 100/1", bus.s_addr_Out, bus.s_isRead_Out); end
      tick();
      bus.s_finish_In    = 1'b1;
      bus.s_data_In      = 32'hDEAD_BEEF;
      bus.s_exception_In = EXC_OK_V;
      checks++; if (bus.a_ok_Out !== 1'b0) begin errors++; $display("[TB] FAIL read_early_ok: got %b want 0", bus.a_ok_Out); end
      tick();
      bus.s_finish_In = 1'b0;
      checks++; if (bus.a_ok_Out !== 1'b1 || bus.b_ok_Out !== 1'b0) begin errors++; $display("[TB] FAIL read_ok: got a %b b %b want 1/0", bus.a_ok_Out, bus.b_ok_Out); end
      checks++; if (bus.a_data_Out !== 32'hDEAD_BEEF || bus.a_exception_Out !== EXC_OK_V) begin errors++; $display("[TB] FAIL read_data: got %h/%h want deadbeef/0", bus.a_data_Out, bus.a_exception_Out); end
      checks++; if (bus.s_select_Out !== 1'b0) begin errors++; $display("[TB] FAIL read_sel_drop: got %b want 0", bus.s_select_Out); end
      bus.a_valid_In = 1'b0;
      tick();
      checks++; if (bus.a_ok_Out !== 1'b0 || bus.grant_Out !== 2'b00) begin errors++; $display("[TB] FAIL read_release: got ok %b grant %b want 0/00", bus.a_ok_Out, bus.grant_Out); end
      checks++; if (bus.a_data_Out !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL read_hold: got %h want deadbeef", bus.a_data_Out); end
      tick();
   endtask

   task automatic test_round_robin;
      logic exp_b;
      logic [31:0] rdata;
      do_reset();
      bus.a_addr_In   = 32'h0000_1000;
      bus.b_addr_In   = 32'h0000_2000;
      bus.a_isRead_In = 1'b1;
      bus.b_isRead_In = 1'b1;
      bus.a_valid_In  = 1'b1;
      bus.b_valid_In  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_b = (i % 2) == 1;
         rdata = 32'hC0DE_0000 + 32'(i);
         tick();
         checks++; if (bus.grant_Out !== (exp_b ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", i, bus.grant_Out, exp_b ? 2'b10 : 2'b01); end
         checks++; if (bus.s_addr_Out !== (exp_b ? 32'h2000 : 32'h1000)) begin errors++; $display("[TB] FAIL rr_addr[%0d]: got %h", i, bus.s_addr_Out); end
         bus.s_finish_In = 1'b1;
         bus.s_data_In   = rdata;
         tick();
         bus.s_finish_In = 1'b0;
         checks++; if ({bus.b_ok_Out, bus.a_ok_Out} !== (exp_b ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL rr_ok[%0d]: got %b want %b", i, {bus.b_ok_Out, bus.a_ok_Out}, exp_b ? 2'b10 : 2'b01); end
         checks++; if ((exp_b ? bus.b_data_Out : bus.a_data_Out) !== rdata) begin errors++; $display("[TB] FAIL rr_data[%0d]: got %h want %h", i, exp_b ? bus.b_data_Out : bus.a_data_Out, rdata); end
         tick();
         tick();
      end
      bus.a_valid_In = 1'b0;
      bus.b_valid_In = 1'b0;
   endtask

   task automatic test_write_b;
      bus.b_addr_In      = 32'h2000_0004;
      bus.b_data_In      = 32'h1234_5678;
      bus.b_dataWidth_In = 2'd2;
      bus.b_isRead_In    = 1'b0;
      bus.b_valid_In     = 1'b1;
      tick();
      checks++; if (bus.s_select_Out !== 1'b1 || bus.grant_Out !== 2'b10) begin errors++; $display("[TB] FAIL wr_grant: got sel %b grant %b want 1/10", bus.s_select_Out, bus.grant_Out); end
      checks++; if (bus.s_addr_Out !== 32'h2000_0004 || bus.s_data_Out !== 32'h1234_5678) begin errors++; $display("[TB] FAIL wr_addr_data: got %h/%h want 20000004/12345678", bus.s_addr_Out, bus.s_data_Out); end
      checks++; if (bus.s_dataWidth_Out !== 2'd2 || bus.s_isRead_Out !== 1'b0) begin errors++; $display("[TB] FAIL wr_width_dir: got %h/%b want 2/0", bus.s_dataWidth_Out, bus.s_isRead_Out); end
      tick();
      bus.s_finish_In    = 1'b1;
      bus.s_data_In      = 32'h0;
      bus.s_exception_In = EXC_OK_V;
      tick();
      bus.s_finish_In = 1'b0;
      checks++; if (bus.b_ok_Out !== 1'b1 || bus.a_ok_Out !== 1'b0 || bus.b_exception_Out !== EXC_OK_V) begin errors++; $display("[TB] FAIL wr_ok: got b %b a %b exc %h want 1/0/0", bus.b_ok_Out, bus.a_ok_Out, bus.b_exception_Out); end
      bus.b_valid_In = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_slave_exception;
      bus.a_addr_In   = 32'h0000_0300;
      bus.a_isRead_In = 1'b1;
      bus.a_valid_In  = 1'b1;
      tick();
      bus.s_finish_In    = 1'b1;
      bus.s_data_In      = 32'h0BAD_F00D;
      bus.s_exception_In = 4'd5;
      tick();
      bus.s_finish_In    = 1'b0;
      bus.s_exception_In = EXC_OK_V;
      checks++; if (bus.a_ok_Out !== 1'b1 || bus.a_exception_Out !== 4'd5) begin errors++; $display("[TB] FAIL exc_ok: got ok %b exc %h want 1/5", bus.a_ok_Out, bus.a_exception_Out); end
      checks++; if (bus.a_data_Out !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL exc_data: got %h want 0badf00d", bus.a_data_Out); end
      bus.a_valid_In = 1'b0;
      tick();
      checks++; if (bus.a_ok_Out !== 1'b0 || bus.a_exception_Out !== 4'd5) begin errors++; $display("[TB] FAIL exc_hold: got ok %b exc %h want 0/5", bus.a_ok_Out, bus.a_exception_Out); end
      tick();
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout;
      bus.a_addr_In  = 32'h0000_0400;
      bus.a_valid_In = 1'b1;
      tick();
      repeat (63) tick();
      checks++; if (bus.s_select_Out !== 1'b1 || bus.a_ok_Out !== 1'b0) begin errors++; $display("[TB] FAIL to_before: got sel %b ok %b want 1/0", bus.s_select_Out, bus.a_ok_Out); end
      tick();
      checks++; if (bus.s_select_Out !== 1'b0 || bus.a_ok_Out !== 1'b1) begin errors++; $display("[TB] FAIL to_fire: got sel %b ok %b want 0/1", bus.s_select_Out, bus.a_ok_Out); end
      checks++; if (bus.a_data_Out !== 32'h0 || bus.a_exception_Out !== EXC_TIMEOUT_V) begin errors++; $display("[TB] FAIL to_resp: got %h/%h want 0/9", bus.a_data_Out, bus.a_exception_Out); end
      bus.a_valid_In     = 1'b0;
      bus.s_finish_In    = 1'b1;
      bus.s_data_In      = 32'h0000_FFFF;
      bus.s_exception_In = 4'd3;
      tick();
      checks++; if (bus.a_ok_Out !== 1'b0 || bus.a_data_Out !== 32'h0 || bus.a_exception_Out !== EXC_TIMEOUT_V) begin errors++; $display("[TB] FAIL to_late: got ok %b %h/%h want 0 0/9", bus.a_ok_Out, bus.a_data_Out, bus.a_exception_Out); end
      tick();
      tick();
      checks++; if (bus.s_select_Out !== 1'b0 || bus.grant_Out !== 2'b00 || bus.a_ok_Out !== 1'b0) begin errors++; $display("[TB] FAIL to_idle: got sel %b grant %b ok %b", bus.s_select_Out, bus.grant_Out, bus.a_ok_Out); end
      bus.s_finish_In    = 1'b0;
      bus.s_exception_In = EXC_OK_V;
      bus.a_valid_In     = 1'b1;
      tick();
      repeat (63) tick();
      bus.s_finish_In = 1'b1;
      bus.s_data_In   = 32'h0000_0055;
      tick();
      bus.s_finish_In = 1'b0;
      checks++; if (bus.a_ok_Out !== 1'b1 || bus.a_data_Out !== 32'h55 || bus.a_exception_Out !== EXC_OK_V) begin errors++; $display("[TB] FAIL to_tie: got ok %b %h/%h want 1 55/0", bus.a_ok_Out, bus.a_data_Out, bus.a_exception_Out); end
      bus.a_valid_In = 1'b0;
      tick();
      tick();
   endtask
`else
   task automatic test_timeout;
      bus.a_addr_In  = 32'h0000_0400;
      bus.a_valid_In = 1'b1;
      tick();
      repeat (80) tick();
      checks++; if (bus.s_select_Out !== 1'b1 || bus.a_ok_Out !== 1'b0 || bus.grant_Out !== 2'b01) begin errors++; $display("[TB] FAIL nto_wait: got sel %b ok %b grant %b want 1/0/01", bus.s_select_Out, bus.a_ok_Out, bus.grant_Out); end
      bus.s_finish_In = 1'b1;
      bus.s_data_In   = 32'h0000_0077;
      tick();
      bus.s_finish_In = 1'b0;
      checks++; if (bus.a_ok_Out !== 1'b1 || bus.a_data_Out !== 32'h77 || bus.a_exception_Out !== EXC_OK_V) begin errors++; $display("[TB] FAIL nto_done: got ok %b %h/%h want 1 77/0", bus.a_ok_Out, bus.a_data_Out, bus.a_exception_Out); end
      bus.a_valid_In = 1'b0;
      tick();
      tick();
   endtask
`endif

   task automatic test_finish_ignored;
      bus.s_finish_In = 1'b1;
      bus.s_data_In   = 32'h1111_2222;
      tick();
      bus.s_finish_In = 1'b0;
      checks++; if ({bus.a_ok_Out, bus.b_ok_Out} !== 2'b00 || bus.s_select_Out !== 1'b0 || bus.grant_Out !== 2'b00) begin errors++; $display("[TB] FAIL stray_finish: got ok %b sel %b grant %b", {bus.a_ok_Out, bus.b_ok_Out}, bus.s_select_Out, bus.grant_Out); end
      tick();
      checks++; if ({bus.a_ok_Out, bus.b_ok_Out} !== 2'b00) begin errors++; $display("[TB] FAIL stray_finish_late: got %b want 00", {bus.a_ok_Out, bus.b_ok_Out}); end
   endtask

   task automatic test_reset_mid_busy;
      bus.a_addr_In  = 32'h0000_0500;
      bus.a_valid_In = 1'b1;
      tick();
      checks++; if (bus.s_select_Out !== 1'b1) begin errors++; $display("[TB] FAIL rmb_busy: got %b want 1", bus.s_select_Out); end
      rst             = 1'b1;
      bus.s_finish_In = 1'b1;
      bus.s_data_In   = 32'hBAD0_BAD0;
      tick();
      checks++; if (bus.s_select_Out !== 1'b0 || bus.grant_Out !== 2'b00 || bus.a_ok_Out !== 1'b0) begin errors++; $display("[TB] FAIL rmb_reset: got sel %b grant %b ok %b want 0/00/0", bus.s_select_Out, bus.grant_Out, bus.a_ok_Out); end
      rst             = 1'b0;
      bus.s_finish_In = 1'b0;
      tick();
      checks++; if (bus.a_ok_Out !== 1'b0 || bus.s_select_Out !== 1'b1 || bus.s_addr_Out !== 32'h500) begin errors++; $display("[TB] FAIL rmb_regrant: got ok %b sel %b addr %h want 0/1/500", bus.a_ok_Out, bus.s_select_Out, bus.s_addr_Out); end
      bus.s_finish_In = 1'b1;
      bus.s_data_In   = 32'h0000_600D;
      tick();
      bus.s_finish_In = 1'b0;
      checks++; if (bus.a_ok_Out !== 1'b1 || bus.a_data_Out !== 32'h600D) begin errors++; $display("[TB] FAIL rmb_after: got ok %b data %h want 1/600d", bus.a_ok_Out, bus.a_data_Out); end
      bus.a_valid_In = 1'b0;
      tick();
      tick();
   endtask

   // Test sequence and summary.
   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.a_addr_In = '0; bus.a_data_In = '0; bus.a_dataWidth_In = '0; bus.a_isRead_In = 1'b0; bus.a_valid_In = 1'b0;
      bus.b_addr_In = '0; bus.b_data_In = '0; bus.b_dataWidth_In = '0; bus.b_isRead_In = 1'b0; bus.b_valid_In = 1'b0;
      bus.s_finish_In = 1'b0; bus.s_data_In = '0; bus.s_exception_In = '0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_b();
      test_slave_exception();
      test_timeout();
      test_finish_ignored();
      test_reset_mid_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
